// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit for the Ranger memory stage.
// Registered request/response engine with byte-lane steering, alignment
// checking, DBus wait handling with a bounded timeout and precise
// exception reporting (RISC-V cause codes 4..7).
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   req_valid/req_ready   execute-stage handshake (ready only in IDLE)
//   lsu_op                operation (lsu_op_t)
//   alu_result            byte address, or data for REG/CSRRW
//   alt_data              store data, or CSR read data
//   endianness            0 = little, 1 = big
//   dest_addr             destination GPR
//   wb_en/wb_addr/wb_data register-file write port (one-cycle pulse)
//   csr_wr_en/csr_wr_data CSR write port (one-cycle pulse)
//   dbus_*                data bus request/response
//   exc_valid/exc_cause/exc_addr  exception report (one-cycle pulse)

package lsu_seq_pkg;

  typedef enum logic [3:0] {
    OP_LB    = 4'd0,
    OP_LH    = 4'd1,
    OP_LW    = 4'd2,
    OP_LBU   = 4'd3,
    OP_LHU   = 4'd4,
    OP_SB    = 4'd5,
    OP_SH    = 4'd6,
    OP_SW    = 4'd7,
    OP_CSRR  = 4'd8,
    OP_CSRRW = 4'd9,
    OP_REG   = 4'd10,
    OP_NOP   = 4'd11
  } lsu_op_t;

endpackage

module lsu_seq
  import lsu_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  lsu_op_t         lsu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alt_data,
  input  logic            endianness,
  input  logic [4:0]      dest_addr,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            csr_wr_en,
  output logic [XLEN-1:0] csr_wr_data,
  output logic            dbus_rd_en,
  output logic            dbus_wr_en,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wr_data,
  output logic [3:0]      dbus_wr_strobe,
  input  logic [XLEN-1:0] dbus_rd_data,
  input  logic            dbus_wait,
  input  logic            dbus_err,
  output logic            exc_valid,
  output logic [3:0]      exc_cause,
  output logic [XLEN-1:0] exc_addr
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Access size: 0 = byte, 1 = halfword, 2 = word.
  function automatic logic [1:0] op_size(input lsu_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
      default:              op_size = 2'd2;
    endcase
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    is_load = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    is_store = op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic misaligned(input lsu_op_t op, input logic [1:0] off);
    case (op_size(op))
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Reverse byte order within the access size (big-endian lane order).
  function automatic logic [XLEN-1:0] lane_swap(input logic [XLEN-1:0] d,
                                                input logic [1:0]      size);
    case (size)
      2'd0:    lane_swap = d;
      2'd1:    lane_swap = {d[31:16], d[7:0], d[15:8]};
      default: lane_swap = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = XLEN'(32'h0000_00FF);
      2'd1:    size_mask = XLEN'(32'h0000_FFFF);
      default: size_mask = XLEN'(32'hFFFF_FFFF);
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input lsu_op_t op, input logic [1:0] off);
    logic [3:0] base;
    case (op_size(op))
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    store_strobe = base << off;
  endfunction

  // Store data: swap for big endian, keep only the accessed bytes, move to lane.
  function automatic logic [XLEN-1:0] store_lanes(input lsu_op_t         op,
                                                  input logic            be,
                                                  input logic [1:0]      off,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] ordered;
    ordered     = be ? lane_swap(d, op_size(op)) : d;
    store_lanes = (ordered & size_mask(op_size(op))) << {off, 3'b000};
  endfunction

  // Load data: move lane to bit 0, swap for big endian, then extend.
  function automatic logic [XLEN-1:0] load_extract(input lsu_op_t         op,
                                                   input logic            be,
                                                   input logic [1:0]      off,
                                                   input logic [XLEN-1:0] d);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ordered;
    shifted = d >> {off, 3'b000};
    ordered = be ? lane_swap(shifted, op_size(op)) : shifted;
    case (op)
      OP_LB:   load_extract = {{24{ordered[7]}}, ordered[7:0]};
      OP_LBU:  load_extract = {24'd0, ordered[7:0]};
      OP_LH:   load_extract = {{16{ordered[15]}}, ordered[15:0]};
      OP_LHU:  load_extract = {16'd0, ordered[15:0]};
      default: load_extract = ordered;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------

  state_t           state_q, state_d;
  lsu_op_t          op_q, op_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic             endian_q, endian_d;
  logic [4:0]       dest_q, dest_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             req_ready_d;
  logic             wb_en_d;
  logic [4:0]       wb_addr_d;
  logic [XLEN-1:0]  wb_data_d;
  logic             csr_wr_en_d;
  logic [XLEN-1:0]  csr_wr_data_d;
  logic             dbus_rd_en_d;
  logic             dbus_wr_en_d;
  logic [XLEN-1:0]  dbus_addr_d;
  logic [XLEN-1:0]  dbus_wr_data_d;
  logic [3:0]       dbus_wr_strobe_d;
  logic             exc_valid_d;
  logic [3:0]       exc_cause_d;
  logic [XLEN-1:0]  exc_addr_d;

  logic             accept_c;
  logic             req_misaligned_c;
  logic             timeout_hit_c;
  logic [XLEN-1:0]  load_data_c;
  logic [3:0]       fault_cause_c;

  assign accept_c         = req_valid && req_ready;
  assign req_misaligned_c = misaligned(lsu_op, alu_result[1:0]);
  // The cycle whose wait would bring the counter to TIMEOUT ends the access.
  assign timeout_hit_c    = (TIMEOUT != 0) &&
                            ((32'(wait_cnt_q) + 32'd1) == 32'(TIMEOUT));
  assign load_data_c      = load_extract(op_q, endian_q, addr_q[1:0], dbus_rd_data);
  assign fault_cause_c    = is_load(op_q) ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && (is_load(lsu_op) || is_store(lsu_op)) && !req_misaligned_c) begin
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (dbus_err || !dbus_wait || timeout_hit_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; pulses default low, everything else holds.
  always_comb begin
    op_d             = op_q;
    addr_d           = addr_q;
    endian_d         = endian_q;
    dest_d           = dest_q;
    wait_cnt_d       = wait_cnt_q;
    req_ready_d      = (state_d == S_IDLE);
    wb_en_d          = 1'b0;
    wb_addr_d        = wb_addr;
    wb_data_d        = wb_data;
    csr_wr_en_d      = 1'b0;
    csr_wr_data_d    = csr_wr_data;
    dbus_rd_en_d     = dbus_rd_en;
    dbus_wr_en_d     = dbus_wr_en;
    dbus_addr_d      = dbus_addr;
    dbus_wr_data_d   = dbus_wr_data;
    dbus_wr_strobe_d = dbus_wr_strobe;
    exc_valid_d      = 1'b0;
    exc_cause_d      = exc_cause;
    exc_addr_d       = exc_addr;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d     = lsu_op;
          addr_d   = alu_result;
          endian_d = endianness;
          dest_d   = dest_addr;
          if (is_load(lsu_op) || is_store(lsu_op)) begin
            if (req_misaligned_c) begin
              exc_valid_d = 1'b1;
              exc_cause_d = is_load(lsu_op) ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
              exc_addr_d  = alu_result;
            end else begin
              wait_cnt_d   = '0;
              dbus_rd_en_d = is_load(lsu_op);
              dbus_wr_en_d = is_store(lsu_op);
              dbus_addr_d  = {alu_result[XLEN-1:2], 2'b00};
              if (is_store(lsu_op)) begin
                dbus_wr_data_d   = store_lanes(lsu_op, endianness, alu_result[1:0], alt_data);
                dbus_wr_strobe_d = store_strobe(lsu_op, alu_result[1:0]);
              end else begin
                dbus_wr_data_d   = '0;
                dbus_wr_strobe_d = 4'b0000;
              end
            end
          end else begin
            case (lsu_op)
              OP_REG: begin
                wb_en_d   = (dest_addr != 5'd0);
                wb_addr_d = dest_addr;
                wb_data_d = alu_result;
              end
              OP_CSRR: begin
                wb_en_d   = (dest_addr != 5'd0);
                wb_addr_d = dest_addr;
                wb_data_d = alt_data;
              end
              OP_CSRRW: begin
                wb_en_d       = (dest_addr != 5'd0);
                wb_addr_d     = dest_addr;
                wb_data_d     = alt_data;
                csr_wr_en_d   = 1'b1;
                csr_wr_data_d = alu_result;
              end
              default: ;
            endcase
          end
        end
      end

      S_BUS: begin
        if (dbus_err || !dbus_wait || timeout_hit_c) begin
          dbus_rd_en_d     = 1'b0;
          dbus_wr_en_d     = 1'b0;
          dbus_addr_d      = '0;
          dbus_wr_data_d   = '0;
          dbus_wr_strobe_d = 4'b0000;
        end
        if (dbus_err || (dbus_wait && timeout_hit_c)) begin
          exc_valid_d = 1'b1;
          exc_cause_d = fault_cause_c;
          exc_addr_d  = addr_q;
        end else if (!dbus_wait) begin
          if (is_load(op_q)) begin
            wb_en_d   = (dest_q != 5'd0);
            wb_addr_d = dest_q;
            wb_data_d = load_data_c;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: ;
    endcase
  end

  // Output and datapath registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= OP_NOP;
      addr_q         <= '0;
      endian_q       <= 1'b0;
      dest_q         <= 5'd0;
      wait_cnt_q     <= '0;
      req_ready      <= 1'b1;
      wb_en          <= 1'b0;
      wb_addr        <= 5'd0;
      wb_data        <= '0;
      csr_wr_en      <= 1'b0;
      csr_wr_data    <= '0;
      dbus_rd_en     <= 1'b0;
      dbus_wr_en     <= 1'b0;
      dbus_addr      <= '0;
      dbus_wr_data   <= '0;
      dbus_wr_strobe <= 4'b0000;
      exc_valid      <= 1'b0;
      exc_cause      <= 4'd0;
      exc_addr       <= '0;
    end else begin
      op_q           <= op_d;
      addr_q         <= addr_d;
      endian_q       <= endian_d;
      dest_q         <= dest_d;
      wait_cnt_q     <= wait_cnt_d;
      req_ready      <= req_ready_d;
      wb_en          <= wb_en_d;
      wb_addr        <= wb_addr_d;
      wb_data        <= wb_data_d;
      csr_wr_en      <= csr_wr_en_d;
      csr_wr_data    <= csr_wr_data_d;
      dbus_rd_en     <= dbus_rd_en_d;
      dbus_wr_en     <= dbus_wr_en_d;
      dbus_addr      <= dbus_addr_d;
      dbus_wr_data   <= dbus_wr_data_d;
      dbus_wr_strobe <= dbus_wr_strobe_d;
      exc_valid      <= exc_valid_d;
      exc_cause      <= exc_cause_d;
      exc_addr       <= exc_addr_d;
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Testbench for lsu_seq (TIMEOUT = 3): directed steps, with writeback, CSR
// and exception pulses checked against an expected-event queue.

module tb_lsu_seq;
  import lsu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     lsu_op;
  logic [31:0] alu_result;
  logic [31:0] alt_data;
  logic        endianness;
  logic [4:0]  dest_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        csr_wr_en;
  logic [31:0] csr_wr_data;
  logic        dbus_rd_en;
  logic        dbus_wr_en;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wr_data;
  logic [3:0]  dbus_wr_strobe;
  logic [31:0] dbus_rd_data;
  logic        dbus_wait;
  logic        dbus_err;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;

  lsu_seq #(.XLEN(32), .TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .lsu_op(lsu_op), .alu_result(alu_result), .alt_data(alt_data),
    .endianness(endianness), .dest_addr(dest_addr), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .csr_wr_en(csr_wr_en),
    .csr_wr_data(csr_wr_data), .dbus_rd_en(dbus_rd_en), .dbus_wr_en(dbus_wr_en),
    .dbus_addr(dbus_addr), .dbus_wr_data(dbus_wr_data),
    .dbus_wr_strobe(dbus_wr_strobe), .dbus_rd_data(dbus_rd_data),
    .dbus_wait(dbus_wait), .dbus_err(dbus_err), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic        csr;
    logic        exc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] cd;
    logic [3:0]  cause;
    logic [31:0] ea;
    int          due;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cycle    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] wa, input logic [31:0] wd, input int due);
    ev_t e;
    e = '{wb: 1'b1, csr: 1'b0, exc: 1'b0, wa: wa, wd: wd, cd: 32'd0,
          cause: 4'd0, ea: 32'd0, due: due};
    sb.push_back(e);
  endtask

  task automatic push_csrwb(input logic [4:0] wa, input logic [31:0] wd,
                            input logic [31:0] cd, input int due);
    ev_t e;
    e = '{wb: 1'b1, csr: 1'b1, exc: 1'b0, wa: wa, wd: wd, cd: cd,
          cause: 4'd0, ea: 32'd0, due: due};
    sb.push_back(e);
  endtask

  task automatic push_exc(input logic [3:0] cause, input logic [31:0] ea, input int due);
    ev_t e;
    e = '{wb: 1'b0, csr: 1'b0, exc: 1'b1, wa: 5'd0, wd: 32'd0, cd: 32'd0,
          cause: cause, ea: ea, due: due};
    sb.push_back(e);
  endtask

  // Advance one clock, sample just after the edge, score any pulse.
  task automatic tick();
    ev_t e;
    logic [31:0] obs_pulses;
    @(posedge clk);
    #1;
    cycle++;
    obs_pulses = {29'd0, wb_en, csr_wr_en, exc_valid};
    if (obs_pulses != 32'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", obs_pulses, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ev_cycle", 32'(cycle), 32'(e.due));
        chk("ev_pulses", obs_pulses, {29'd0, e.wb, e.csr, e.exc});
        if (e.wb) begin
          chk("ev_wb_addr", {27'd0, wb_addr}, {27'd0, e.wa});
          chk("ev_wb_data", wb_data, e.wd);
        end
        if (e.csr) chk("ev_csr_data", csr_wr_data, e.cd);
        if (e.exc) begin
          chk("ev_exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
          chk("ev_exc_addr", exc_addr, e.ea);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      chk("missing_pulse", obs_pulses, {29'd0, e.wb, e.csr, e.exc});
    end
  endtask

  task automatic issue(input lsu_op_t op, input logic [31:0] a, input logic [31:0] d,
                       input logic be, input logic [4:0] dst);
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    lsu_op     = op;
    alu_result = a;
    alt_data   = d;
    endianness = be;
    dest_addr  = dst;
    tick();
    req_valid  = 1'b0;
    lsu_op     = OP_NOP;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_en"},     {31'd0, wb_en}, 32'd0);
    chk({tag, "_wb_addr"},   {27'd0, wb_addr}, 32'd0);
    chk({tag, "_wb_data"},   wb_data, 32'd0);
    chk({tag, "_csr_en"},    {31'd0, csr_wr_en}, 32'd0);
    chk({tag, "_csr_data"},  csr_wr_data, 32'd0);
    chk({tag, "_rd_en"},     {31'd0, dbus_rd_en}, 32'd0);
    chk({tag, "_wr_en"},     {31'd0, dbus_wr_en}, 32'd0);
    chk({tag, "_dbus_addr"}, dbus_addr, 32'd0);
    chk({tag, "_wr_data"},   dbus_wr_data, 32'd0);
    chk({tag, "_strobe"},    {28'd0, dbus_wr_strobe}, 32'd0);
    chk({tag, "_exc"},       {31'd0, exc_valid}, 32'd0);
    chk({tag, "_cause"},     {28'd0, exc_cause}, 32'd0);
    chk({tag, "_exc_addr"},  exc_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    lsu_op       = OP_NOP;
    alu_result   = 32'd0;
    alt_data     = 32'd0;
    endianness   = 1'b0;
    dest_addr    = 5'd0;
    dbus_rd_data = 32'd0;
    dbus_wait    = 1'b0;
    dbus_err     = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back REG then CSRRW
    push_wb(5'd3, 32'h0000_0055, cycle + 1);
    issue(OP_REG, 32'h0000_0055, 32'h0, 1'b0, 5'd3);
    push_csrwb(5'd7, 32'h1111_2222, 32'h0000_A5A5, cycle + 1);
    issue(OP_CSRRW, 32'h0000_A5A5, 32'h1111_2222, 1'b0, 5'd7);
    tick();

    // x0 destination suppressed; CSRR to a real register
    issue(OP_REG, 32'h0000_0077, 32'h0, 1'b0, 5'd0);
    push_wb(5'd5, 32'hDEAD_BEEF, cycle + 1);
    issue(OP_CSRR, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd5);
    tick();

    // LB at 0x1003, little endian, zero wait
    dbus_rd_data = 32'h80FF_0000;
    push_wb(5'd9, 32'hFFFF_FF80, cycle + 2);
    issue(OP_LB, 32'h0000_1003, 32'h0, 1'b0, 5'd9);
    chk("lb_rd_en", {31'd0, dbus_rd_en}, 32'd1);
    chk("lb_wr_en", {31'd0, dbus_wr_en}, 32'd0);
    chk("lb_dbus_addr", dbus_addr, 32'h0000_1000);
    chk("lb_busy", {31'd0, req_ready}, 32'd0);
    tick();
    chk("lb_rd_drop", {31'd0, dbus_rd_en}, 32'd0);
    chk("lb_ready_back", {31'd0, req_ready}, 32'd1);

    // SH at 0x2002, big endian
    issue(OP_SH, 32'h0000_2002, 32'h0000_1234, 1'b1, 5'd4);
    chk("sh_wr_en", {31'd0, dbus_wr_en}, 32'd1);
    chk("sh_dbus_addr", dbus_addr, 32'h0000_2000);
    chk("sh_strobe", {28'd0, dbus_wr_strobe}, 32'h0000_000C);
    chk("sh_wr_data", dbus_wr_data, 32'h3412_0000);
    tick();
    chk("sh_wr_drop", {31'd0, dbus_wr_en}, 32'd0);
    tick();

    // Misaligned LW and SW, back-to-back
    push_exc(4'd4, 32'h0000_3001, cycle + 1);
    issue(OP_LW, 32'h0000_3001, 32'h0, 1'b0, 5'd8);
    chk("lw_mis_no_bus", {31'd0, dbus_rd_en}, 32'd0);
    chk("lw_mis_ready", {31'd0, req_ready}, 32'd1);
    push_exc(4'd6, 32'h0000_3002, cycle + 1);
    issue(OP_SW, 32'h0000_3002, 32'hFFFF_FFFF, 1'b0, 5'd0);
    chk("sw_mis_no_bus", {31'd0, dbus_wr_en}, 32'd0);
    tick();

    // LHU timeout after 3 wait cycles
    dbus_wait = 1'b1;
    push_exc(4'd5, 32'h0000_4002, cycle + 4);
    issue(OP_LHU, 32'h0000_4002, 32'h0, 1'b0, 5'd4);
    for (int i = 0; i < 2; i++) begin
      chk("to_rd_stable", {31'd0, dbus_rd_en}, 32'd1);
      chk("to_addr_stable", dbus_addr, 32'h0000_4000);
      tick();
    end
    chk("to_rd_last", {31'd0, dbus_rd_en}, 32'd1);
    tick();
    chk("to_rd_drop", {31'd0, dbus_rd_en}, 32'd0);
    dbus_wait = 1'b0;
    tick();

    // SW with bus error in first bus cycle
    issue(OP_SW, 32'h0000_5000, 32'hCAFE_BABE, 1'b0, 5'd0);
    chk("sw_wr_data", dbus_wr_data, 32'hCAFE_BABE);
    chk("sw_strobe", {28'd0, dbus_wr_strobe}, 32'h0000_000F);
    dbus_err = 1'b1;
    push_exc(4'd7, 32'h0000_5000, cycle + 1);
    tick();
    dbus_err = 1'b0;
    tick();

    // Error wins over a simultaneous completion
    issue(OP_LW, 32'h0000_6000, 32'h0, 1'b0, 5'd2);
    dbus_err = 1'b1;
    push_exc(4'd5, 32'h0000_6000, cycle + 1);
    tick();
    dbus_err = 1'b0;
    tick();

    // LH at 0x7002, big endian, two wait states
    dbus_rd_data = 32'hBEEF_0000;
    dbus_wait    = 1'b1;
    push_wb(5'd11, 32'hFFFF_EFBE, cycle + 4);
    issue(OP_LH, 32'h0000_7002, 32'h0, 1'b1, 5'd11);
    tick();
    tick();
    dbus_wait = 1'b0;
    tick();
    tick();

    // Reset in the 3rd bus cycle of a stalled LW
    dbus_wait = 1'b1;
    issue(OP_LW, 32'h0000_0100, 32'h0, 1'b0, 5'd6);
    tick();
    tick();
    chk("rst_mid_busy", {31'd0, dbus_rd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_no_bus", {31'd0, dbus_rd_en}, 32'd0);
    dbus_wait = 1'b0;
    tick();
    tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Sequential, parametrised load/store unit for the Ranger core's memory stage. It replaces the purely combinational LSU with a registered request/response engine. It adds byte-lane steering for sub-word accesses at any legal offset, misalignment detection, DBus wait handling with a bounded timeout, and precise exception reporting with RISC-V cause codes. It sits between the execute stage (ALU result, store/CSR data) and the register-file write port, DBus, CSR file and trap unit.

## Interface
- XLEN, 32, data/address width; must be 32 for rv32.
- TIMEOUT, 15, maximum consecutive `dbus_wait` cycles before an access fault is raised; 0 disables the timeout.

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  LSU accepts an operation this cycle
- lsu_op  in  lsu_op_t  operation (LB/LH/LW/LBU/LHU/SB/SH/SW/CSRR/CSRRW/REG/NOP)
- alu_result  in  XLEN  byte address, or data for REG/CSRRW
- alt_data  in  XLEN  store data, or CSR read data
- endianness  in  1  0 = little, 1 = big
- dest_addr  in  5  destination GPR
- wb_en  out  1  register-file write strobe (one-cycle pulse)
- wb_addr  out  5  write address
- wb_data  out  XLEN  write data
- csr_wr_en  out  1  CSR write pulse
- csr_wr_data  out  XLEN  CSR write data
- dbus_rd_en, dbus_wr_en  out  1  bus read/write request
- dbus_addr  out  XLEN  word-aligned bus address
- dbus_wr_data  out  XLEN  lane-steered store data
- dbus_wr_strobe  out  4  byte-lane enables
- dbus_rd_data  in  XLEN  read data
- dbus_wait  in  1  bus not ready; hold the request
- dbus_err  in  1  bus error; abort the access
- exc_valid  out  1  exception pulse
- exc_cause  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault
- exc_addr  out  XLEN  faulting byte address (mtval)

## Operation
- **States**: IDLE and BUS.
- **`req_ready`**: equals 1 in IDLE and 0 in BUS.
- **Accept**: an operation is accepted on a clock edge where `req_valid && req_ready`. The op, address, data, `endianness` and `dest_addr` are latched at that edge.
- **REG, CSRR, CSRRW, NOP**: stay in IDLE.
  - Next cycle: `wb_en` = 1 for REG/CSRR/CSRRW.
  - `wb_data` = `alu_result` for REG; `alt_data` for CSRR/CSRRW.
  - CSRRW also pulses `csr_wr_en` with `csr_wr_data` = `alu_result`.
- **Alignment check at accept**:
  - Halfword accesses require `addr[0]` = 0.
  - Word accesses require `addr[1:0]` = 0.
  - A violation skips the bus. Next cycle: `exc_valid` = 1, cause 4 (load) or 6 (store), `exc_addr` = address.
- **Aligned load/store**: go to BUS.
  - `dbus_addr` = {addr[31:2], 2'b00}. Let off = addr[1:0].
  - Stores: strobe = 0001, 0011 or 1111 for SB/SH/SW, shifted left by off.
  - Store data: for big endian, bytes are first reversed within the access size. The value is then shifted left by 8*off.
  - Loads: `dbus_rd_data` is shifted right by 8*off, then byte-reversed within the access size if big endian, then sign- or zero-extended per op.
- **BUS exits**, evaluated each cycle in priority order:
  1. `dbus_err` = 1: access fault (cause 5 or 7) and go to IDLE.
  2. `dbus_wait` = 0: completion and go to IDLE. Loads pulse `wb_en` next cycle; stores pulse nothing.
  3. Otherwise the wait counter increments. When it reaches TIMEOUT (nonzero), an access fault is raised and the FSM goes to IDLE.
- **Wait counter**: cleared on entry to BUS.
- **x0 destination**: `wb_en` is suppressed when `dest_addr` = 0.
- **Exclusivity**: `wb_en` and `exc_valid` are never both 1.

## Timing
- All outputs are registered.
- **Reset values** (asynchronous on `rst_n` low): state IDLE, `req_ready` = 1 once out of reset, all other outputs 0. A bus access in flight is dropped immediately, with no writeback and no exception.
- **Non-memory op**: accepted at edge t, result visible in cycle t+1. Throughput is one per cycle.
- **Memory op, zero wait**: accepted at edge t; bus request asserted in cycle t+1; `wb_en` in cycle t+2.
- **Wait states**: each `dbus_wait` cycle adds one cycle of latency.
- **Bus outputs in BUS**: `dbus_*` request outputs stay stable throughout BUS and drop to 0 in the cycle after the exit edge.
- **Pulse width**: `wb_en`, `csr_wr_en` and `exc_valid` are exactly one cycle wide.
- **Back-to-back**: a new request may be accepted in the same cycle as a completion pulse, because the FSM is already back in IDLE.
- **Simultaneous `dbus_err` and `dbus_wait` = 0**: the error wins.

## Test plan
- **Reset mid-access**: LW at 0x100 with `dbus_wait` held 1, then `rst_n` pulsed low in the 3rd BUS cycle -> all outputs 0, no `wb_en`, `req_ready` = 1 after release.
- **LB at 0x1003, little endian**: `dbus_rd_data` = 0x80FF_0000 -> `dbus_addr` 0x1000, `wb_data` 0xFFFF_FF80, `wb_en` 2 cycles after accept.
- **SH at 0x2002, big endian**: `alt_data` = 0x0000_1234 -> strobe 1100, `dbus_wr_data` 0x3412_0000, no `wb_en`.
- **LW at 0x3001** -> no bus request; `exc_valid` with cause 4 and `exc_addr` 0x3001 next cycle. **SW at 0x3002** -> cause 6.
- **Timeout (TIMEOUT = 3)**: LHU with `dbus_wait` stuck 1 -> cause 5 after 3 wait cycles. **Fault**: SW with `dbus_err` = 1 in the first BUS cycle -> cause 7.
- **Back-to-back**: REG (`alu_result` 0x55, `dest_addr` 3) then CSRRW on consecutive cycles -> `wb_en` on two consecutive cycles, `csr_wr_en` on the second only. **x0**: REG to `dest_addr` 0 -> no `wb_en`.
